// File: rtl/xbus_slave_responder_bfm.sv
// rtl/xbus_slave_responder_bfm.sv - XBus slave responder: decodes, waits, drives read data, reports writes.
// Optional response timeout: define XBUS_SLV_RSP_TIMEOUT_EN.
module xbus_slave_responder_bfm #(
    parameter logic [15:0] ADDR_LO = 16'h0000,
    parameter logic [15:0] ADDR_HI = 16'h7FFF,
    parameter int          WAIT_W  = 4
) (
    input  logic              sig_clock,
    input  logic              sig_reset,
    input  logic [15:0]       sig_addr,
    input  logic [1:0]        sig_size,
    input  logic              sig_read,
    input  logic              sig_write,
    input  logic [7:0]        sig_data_in,
    output logic [7:0]        sig_data_out,
    output logic              sig_data_oe,
    output logic              sig_wait,
    output logic              sig_error,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [63:0]       rsp_data,
    input  logic [WAIT_W-1:0] rsp_wait,
    input  logic              rsp_error,
    output logic              wr_valid,
    output logic [15:0]       wr_addr,
    output logic [1:0]        wr_size,
    output logic [63:0]       wr_data,
    output logic [7:0]        proto_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_RSP,
        S_WAIT,
        S_XFER
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              is_read_q, is_read_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [63:0]       rsp_data_q, rsp_data_d;
    logic [WAIT_W-1:0] rsp_wait_q, rsp_wait_d;
    logic              rsp_error_q, rsp_error_d;
    logic [63:0]       wr_buf_q, wr_buf_d;

    logic [7:0]        data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic              wait_q, wait_d;
    logic              error_q, error_d;
    logic              rsp_ready_q, rsp_ready_d;
    logic              wr_valid_q, wr_valid_d;
    logic [15:0]       wr_addr_q, wr_addr_d;
    logic [1:0]        wr_size_q, wr_size_d;
    logic [63:0]       wr_data_q, wr_data_d;
    logic [7:0]        proto_cnt_q, proto_cnt_d;
`ifdef XBUS_SLV_RSP_TIMEOUT_EN
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    logic in_range;
    logic accept;
    logic violation;

    function automatic logic [2:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            2'b10:   last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    endfunction

    // +1 on the low bound keeps the check well-formed when ADDR_LO is zero
    assign in_range  = (({1'b0, sig_addr} + 17'd1) > {1'b0, ADDR_LO}) && (sig_addr <= ADDR_HI);
    assign accept    = (state_q == S_IDLE) && (sig_read ^ sig_write) && in_range;
    assign violation = (sig_read & sig_write) || ((sig_read | sig_write) && (state_q != S_IDLE));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        is_read_d   = is_read_q;
        byte_idx_d  = byte_idx_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_wait_d  = rsp_wait_q;
        rsp_error_d = rsp_error_q;
        wr_buf_d    = wr_buf_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_size_d   = wr_size_q;
        wr_data_d   = wr_data_q;
        proto_cnt_d = proto_cnt_q;
`ifdef XBUS_SLV_RSP_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        if (violation && (proto_cnt_q != 8'hFF)) begin
            proto_cnt_d = proto_cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d     = sig_addr;
                    size_d     = sig_size;
                    is_read_d  = sig_read;
                    byte_idx_d = 3'd0;
                    wr_buf_d   = 64'd0;
                    state_d    = S_GET_RSP;
`ifdef XBUS_SLV_RSP_TIMEOUT_EN
                    tmo_cnt_d  = 8'd0;
`endif
                end
            end
            S_GET_RSP: begin
                if (rsp_valid && rsp_ready_q) begin
                    rsp_data_d  = rsp_data;
                    rsp_wait_d  = rsp_wait;
                    rsp_error_d = rsp_error;
                    wait_cnt_d  = rsp_wait;
                    state_d     = (rsp_wait != '0) ? S_WAIT : S_XFER;
                end
`ifdef XBUS_SLV_RSP_TIMEOUT_EN
                else if (tmo_cnt_q == 8'hFF) begin
                    rsp_data_d  = {64{1'b1}};
                    rsp_wait_d  = '0;
                    rsp_error_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = S_XFER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q == WAIT_W'(1)) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (!is_read_q) begin
                    wr_buf_d[{byte_idx_q, 3'b000} +: 8] = sig_data_in;
                end
                if (byte_idx_q == last_idx(size_q)) begin
                    state_d = S_IDLE;
                    if (!is_read_q) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_size_d  = size_q;
                        wr_data_d  = wr_buf_d;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    wait_cnt_d = rsp_wait_q;
                    state_d    = (rsp_wait_q != '0) ? S_WAIT : S_XFER;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus-facing outputs are registered from the next-state view so they line up with the state
        wait_d      = (state_d == S_GET_RSP) || (state_d == S_WAIT);
        rsp_ready_d = (state_d == S_GET_RSP);
        data_oe_d   = (state_d == S_XFER) && is_read_d;
        data_out_d  = data_oe_d ? rsp_data_d[{byte_idx_d, 3'b000} +: 8] : data_out_q;
        error_d     = (state_d == S_XFER) && (byte_idx_d == last_idx(size_d)) && rsp_error_d;
    end

    always_ff @(posedge sig_clock) begin
        if (!sig_reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'd0;
            size_q      <= 2'd0;
            is_read_q   <= 1'b0;
            byte_idx_q  <= 3'd0;
            wait_cnt_q  <= '0;
            rsp_data_q  <= 64'd0;
            rsp_wait_q  <= '0;
            rsp_error_q <= 1'b0;
            wr_buf_q    <= 64'd0;
            data_out_q  <= 8'd0;
            data_oe_q   <= 1'b0;
            wait_q      <= 1'b0;
            error_q     <= 1'b0;
            rsp_ready_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 16'd0;
            wr_size_q   <= 2'd0;
            wr_data_q   <= 64'd0;
            proto_cnt_q <= 8'd0;
`ifdef XBUS_SLV_RSP_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            is_read_q   <= is_read_d;
            byte_idx_q  <= byte_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_wait_q  <= rsp_wait_d;
            rsp_error_q <= rsp_error_d;
            wr_buf_q    <= wr_buf_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            wait_q      <= wait_d;
            error_q     <= error_d;
            rsp_ready_q <= rsp_ready_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_size_q   <= wr_size_d;
            wr_data_q   <= wr_data_d;
            proto_cnt_q <= proto_cnt_d;
`ifdef XBUS_SLV_RSP_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign sig_data_out  = data_out_q;
    assign sig_data_oe   = data_oe_q;
    assign sig_wait      = wait_q;
    assign sig_error     = error_q;
    assign rsp_ready     = rsp_ready_q;
    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_size       = wr_size_q;
    assign wr_data       = wr_data_q;
    assign proto_err_cnt = proto_cnt_q;

endmodule

// File: tb/tb_xbus_slave_responder_bfm.sv
// tb/tb_xbus_slave_responder_bfm.sv - table-driven bench for xbus_slave_responder_bfm.
module tb_xbus_slave_responder_bfm;

    logic        sig_clock = 1'b0;
    logic        sig_reset;
    logic [15:0] sig_addr;
    logic [1:0]  sig_size;
    logic        sig_read;
    logic        sig_write;
    logic [7:0]  sig_data_in;
    logic [7:0]  sig_data_out;
    logic        sig_data_oe;
    logic        sig_wait;
    logic        sig_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_wait;
    logic        rsp_error;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [1:0]  wr_size;
    logic [63:0] wr_data;
    logic [7:0]  proto_err_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 sig_clock = ~sig_clock;

    xbus_slave_responder_bfm dut (
        .sig_clock     (sig_clock),
        .sig_reset     (sig_reset),
        .sig_addr      (sig_addr),
        .sig_size      (sig_size),
        .sig_read      (sig_read),
        .sig_write     (sig_write),
        .sig_data_in   (sig_data_in),
        .sig_data_out  (sig_data_out),
        .sig_data_oe   (sig_data_oe),
        .sig_wait      (sig_wait),
        .sig_error     (sig_error),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_wait      (rsp_wait),
        .rsp_error     (rsp_error),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_size       (wr_size),
        .wr_data       (wr_data),
        .proto_err_cnt (proto_err_cnt)
    );

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        logic [3:0]  wt;
        logic        err;
        int          dly;
        logic        acc;
        logic [63:0] exp_wr;
    } vec_t;

    vec_t vecs[8];

    task automatic step;
        @(posedge sig_clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wait"}, sig_wait, 0);
        chk({tag, "_oe"}, sig_data_oe, 0);
        chk({tag, "_err"}, sig_error, 0);
        chk({tag, "_rdy"}, rsp_ready, 0);
        chk({tag, "_wrv"}, wr_valid, 0);
        chk({tag, "_dout"}, sig_data_out, 0);
        chk({tag, "_wdata"}, wr_data, 0);
        chk({tag, "_waddr"}, wr_addr, 0);
        chk({tag, "_pcnt"}, proto_err_cnt, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int nb;
        sig_addr  = v.addr;
        sig_size  = v.size;
        sig_read  = v.rd;
        sig_write = !v.rd;
        rsp_data  = v.data;
        rsp_wait  = v.wt;
        rsp_error = v.err;
        rsp_valid = (v.dly == 0);
        step;
        sig_read  = 1'b0;
        sig_write = 1'b0;
        if (!v.acc) begin
            for (int i = 0; i < 3; i++) begin
                chk("oor_wait", sig_wait, 0);
                chk("oor_oe", sig_data_oe, 0);
                chk("oor_rdy", rsp_ready, 0);
                step;
            end
            return;
        end
        chk("getrsp_wait", sig_wait, 1);
        chk("getrsp_rdy", rsp_ready, 1);
        for (int i = 0; i < v.dly; i++) begin
            step;
            chk("dly_wait", sig_wait, 1);
            chk("dly_oe", sig_data_oe, 0);
        end
        rsp_valid = 1'b1;
        nb = 1 << v.size;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < int'(v.wt); w++) begin
                step;
                chk("wait_cyc", sig_wait, 1);
                chk("wait_oe", sig_data_oe, 0);
            end
            step;
            chk("xfer_wait", sig_wait, 0);
            chk("xfer_oe", sig_data_oe, v.rd);
            chk("xfer_rdy", rsp_ready, 0);
            if (v.rd) chk("rdata", sig_data_out, v.data[b*8 +: 8]);
            chk("xfer_err", sig_error, (b == nb - 1) && v.err);
            if (!v.rd) sig_data_in = v.data[b*8 +: 8];
        end
        rsp_valid = 1'b0;
        step;
        chk("post_wait", sig_wait, 0);
        chk("post_oe", sig_data_oe, 0);
        chk("post_err", sig_error, 0);
        chk("wr_valid", wr_valid, !v.rd);
        if (!v.rd) begin
            chk("wr_addr", wr_addr, v.addr);
            chk("wr_size", wr_size, v.size);
            chk("wr_data", wr_data, v.exp_wr);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0010, 2'b01, 64'h0000_0000_0000_BBAA, 4'd0, 1'b0, 0, 1'b1, 64'd0};
        vecs[1] = '{1'b0, 16'h0100, 2'b10, 64'h0000_0000_4433_2211, 4'd2, 1'b0, 0, 1'b1, 64'h0000_0000_4433_2211};
        vecs[2] = '{1'b1, 16'h9000, 2'b00, 64'h0000_0000_0000_0055, 4'd0, 1'b0, 0, 1'b0, 64'd0};
        vecs[3] = '{1'b1, 16'h0200, 2'b11, 64'h8877_6655_4433_2211, 4'd1, 1'b1, 0, 1'b1, 64'd0};
        vecs[4] = '{1'b1, 16'h0300, 2'b00, 64'h0000_0000_0000_005A, 4'd0, 1'b0, 5, 1'b1, 64'd0};
        vecs[5] = '{1'b0, 16'h7FFF, 2'b00, 64'hFFFF_FFFF_FFFF_FFC3, 4'd0, 1'b1, 0, 1'b1, 64'h0000_0000_0000_00C3};
        vecs[6] = '{1'b1, 16'h0000, 2'b10, 64'h0000_0000_DEAD_BEEF, 4'd3, 1'b0, 0, 1'b1, 64'd0};
        vecs[7] = '{1'b1, 16'h8000, 2'b00, 64'h0000_0000_0000_0011, 4'd0, 1'b0, 0, 1'b0, 64'd0};

        sig_reset   = 1'b0;
        sig_addr    = 16'd0;
        sig_size    = 2'd0;
        sig_read    = 1'b0;
        sig_write   = 1'b0;
        sig_data_in = 8'd0;
        rsp_valid   = 1'b0;
        rsp_data    = 64'd0;
        rsp_wait    = 4'd0;
        rsp_error   = 1'b0;
        repeat (3) step;
        chk_all_zero("reset");
        sig_reset = 1'b1;
        step;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end
        chk("pcnt_clean", proto_err_cnt, 0);

        // Request while busy is counted and ignored; the in-flight read still completes
        sig_addr = 16'h0020; sig_size = 2'b00; sig_read = 1'b1;
        rsp_valid = 1'b0;
        step;
        sig_read = 1'b0;
        sig_write = 1'b1; sig_addr = 16'h0040;
        step;
        sig_write = 1'b0;
        chk("busy_pcnt", proto_err_cnt, 1);
        chk("busy_wait", sig_wait, 1);
        chk("busy_rdy", rsp_ready, 1);
        rsp_valid = 1'b1; rsp_data = 64'h77; rsp_wait = 4'd0; rsp_error = 1'b0;
        step;
        rsp_valid = 1'b0;
        chk("busy_oe", sig_data_oe, 1);
        chk("busy_data", sig_data_out, 8'h77);
        step;
        chk("busy_done", sig_wait, 0);

        // Both strobes for 300 cycles: never a request, counter saturates
        sig_read = 1'b1; sig_write = 1'b1; sig_addr = 16'h0050;
        step;
        chk("both_pcnt1", proto_err_cnt, 2);
        for (int i = 0; i < 299; i++) begin
            step;
            if (sig_wait !== 1'b0 || rsp_ready !== 1'b0) chk("both_no_xfer", {sig_wait, rsp_ready}, 0);
        end
        chk("both_wait", sig_wait, 0);
        chk("both_pcnt_sat", proto_err_cnt, 255);
        sig_read = 1'b0; sig_write = 1'b0;
        step;
        chk("both_hold", proto_err_cnt, 255);

        // Reset during byte 1 of an 8-byte write aborts it without a wr_valid
        sig_addr = 16'h0400; sig_size = 2'b11; sig_write = 1'b1;
        rsp_valid = 1'b1; rsp_wait = 4'd0; rsp_error = 1'b0;
        step;
        sig_write = 1'b0;
        step;
        chk("abort_b0_wait", sig_wait, 0);
        sig_data_in = 8'hA1;
        step;
        sig_data_in = 8'hA2;
        rsp_valid = 1'b0;
        sig_reset = 1'b0;
        step;
        chk_all_zero("abort");
        sig_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("abort_no_wrv", wr_valid, 0);
            chk("abort_idle", sig_wait, 0);
        end
        run_vec(vecs[0]);

`ifdef XBUS_SLV_RSP_TIMEOUT_EN
        sig_addr = 16'h0060; sig_size = 2'b00; sig_read = 1'b1;
        rsp_valid = 1'b0;
        step;
        sig_read = 1'b0;
        for (int i = 0; i < 255; i++) begin
            if (sig_wait !== 1'b1) chk("tmo_wait", sig_wait, 1);
            step;
        end
        chk("tmo_last_wait", sig_wait, 1);
        step;
        chk("tmo_oe", sig_data_oe, 1);
        chk("tmo_data", sig_data_out, 8'hFF);
        chk("tmo_err", sig_error, 1);
        step;
        chk("tmo_done", sig_wait, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/xbus_slave_responder_bfm.md
Name: xbus_slave_responder_bfm

Overview:
- Active XBus slave BFM; the responding end of the bus that the slave monitor only observes.
- Decodes address phases in its range and drives sig_wait and read data.
- Captures write data and reports completed writes on a side port.
- Per-transfer wait count, read data and error flag come from a response port fed by the SCE-MI input-pipe receive wrapper of the slave driver UVC.

Parameters:
ADDR_LO, 16'h0000, lowest decoded address (inclusive)
ADDR_HI, 16'h7FFF, highest decoded address (inclusive)
WAIT_W, 4, width of per-byte wait count

Ports:
sig_clock  in  1  bus clock; all logic on posedge
sig_reset  in  1  synchronous reset, active-low (0 = reset)
sig_addr  in  16  address, valid in address phase
sig_size  in  2  transfer size: 00=1, 01=2, 10=4, 11=8 bytes
sig_read  in  1  read address phase
sig_write  in  1  write address phase
sig_data_in  in  8  bus data, sampled on write transfers
sig_data_out  out  8  read data driven to bus
sig_data_oe  out  1  read data drive enable
sig_wait  out  1  slave wait
sig_error  out  1  error flag on final transfer byte
rsp_valid  in  1  response word available
rsp_ready  out  1  block accepts response word
rsp_data  in  64  read data; byte i = bits [8i+7:8i]
rsp_wait  in  WAIT_W  wait cycles inserted before each byte
rsp_error  in  1  flag transfer as error
wr_valid  out  1  one-cycle pulse: write completed
wr_addr  out  16  address of completed write
wr_size  out  2  size of completed write
wr_data  out  64  captured write bytes, zero-extended above size
proto_err_cnt  out  8  saturating protocol-violation count

Behaviour:
- Reset (sig_reset=0 at posedge): state IDLE; all outputs 0; counters, byte index, latched response cleared; pending write discarded. Applies mid-transfer; no wr_valid is emitted for an aborted write.
- Address-phase detect:
  - In IDLE, exactly one of sig_read/sig_write =1 and ADDR_LO<=sig_addr<=ADDR_HI: latch addr, size and direction; nbytes=1<<size; byte_idx=0; go to GET_RSP.
  - Out-of-range address: ignored, remain IDLE.
- Protocol violations: proto_err_cnt += 1, saturating at 255, for:
  - sig_read & sig_write both 1 in any state; also ignored as a request.
  - sig_read|sig_write asserted while not IDLE; also ignored as a request.
- GET_RSP:
  - sig_wait=1, rsp_ready=1.
  - On rsp_valid&rsp_ready: latch rsp_data, rsp_wait, rsp_error; wait_cnt=rsp_wait; go to WAIT if rsp_wait!=0, else XFER.
  - rsp_ready is 1 only in GET_RSP.
- WAIT: sig_wait=1; wait_cnt decrements each cycle; at wait_cnt==1 the next state is XFER.
- XFER (one byte per cycle):
  - sig_wait=0.
  - Read: sig_data_oe=1, sig_data_out=rsp byte[byte_idx].
  - Write: sig_data_in captured into wr buffer byte[byte_idx].
  - Not last byte: byte_idx++; reload wait_cnt=latched rsp_wait; next state WAIT if nonzero, else XFER.
  - Last byte (byte_idx==nbytes-1): sig_error=latched rsp_error this cycle only; next state IDLE.
  - Write last byte: wr_valid pulses in the following cycle with wr_addr/wr_size/wr_data.
- Timing:
  - Address phase at edge k → sig_wait=1 from k+1.
  - If rsp_valid is already high at k+1, first XFER is at k+2+rsp_wait.
- Outputs are registered. sig_data_out holds its last value when oe=0; benches check it only while oe=1.
- Back-to-back: a new address phase is accepted in the first IDLE cycle after the last XFER.

Optional Feature:
XBUS_SLV_RSP_TIMEOUT_EN:
- Defined: an 8-bit counter runs in GET_RSP. If rsp_valid has not been seen after 256 cycles, the block self-generates a response: data 64'hFF..FF, wait 0, error 1. rsp_ready then drops. The transfer completes with sig_error on the last byte.
- Undefined: GET_RSP waits indefinitely with sig_wait=1.

Test Plan:
1. Read addr 16'h0010 size 01, rsp_data 64'h..BBAA, rsp_wait 0, rsp_valid held high → sig_wait 1 one cycle, then oe=1 two cycles with data AA then BB, sig_error 0.
2. Write addr 16'h0100 size 10, bus bytes 11,22,33,44, rsp_wait 2 → two sig_wait=1 cycles before each byte. Then one wr_valid pulse with wr_data 64'h0000_0000_4433_2211, wr_addr 16'h0100, wr_size 10.
3. Read addr 16'h9000 → no response: sig_wait, oe, rsp_ready stay 0. Read with rsp_error=1, size 11 → sig_error high only on 8th byte.
4. sig_read=sig_write=1 for 300 cycles → no transfer; proto_err_cnt reaches 255 and holds.
5. Reset driven low after byte 1 of an 8-byte write → next cycle all outputs 0, IDLE, no wr_valid. A following read completes normally.
6. rsp_valid delayed 5 cycles → sig_wait held 5 extra cycles, data correct. With XBUS_SLV_RSP_TIMEOUT_EN and rsp_valid never asserted, 1-byte read → after 256 cycles data 8'hFF with sig_error=1.
